// File: rtl/reg_dump_reader.sv
// Streams a masked subset of the 16 register words out over valid/ready, lowest index first.
// Optional checksum beat (XOR of all register beats) when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int IDXW  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [NREG*WIDTH-1:0] i_q_flat,
  input  logic                  i_start,
  input  logic [NREG-1:0]       i_mask,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data_out,
  output logic [IDXW-1:0]       o_reg_idx,
  output logic                  o_last,
  output logic                  o_is_csum,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;

  state_t            r_state;
  logic [NREG-1:0]   r_mask;
  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [IDXW-1:0]   r_idx;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
`ifdef REG_DUMP_CHECKSUM_EN
  logic              r_isCsum;
  logic [WIDTH-1:0]  r_xor;
`endif

  logic [IDXW-1:0]   w_startIdx;
  logic [IDXW-1:0]   w_nextIdx;
  logic [WIDTH-1:0]  w_startWord;
  logic [WIDTH-1:0]  w_nextWord;
  logic [NREG-1:0]   w_startRest;
  logic [NREG-1:0]   w_nextRest;
  logic              w_startLast;
  logic              w_nextLast;

  function automatic logic [IDXW-1:0] lowestIdx(input logic [NREG-1:0] m);
    lowestIdx = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if (m[k]) lowestIdx = IDXW'(k);
    end
  endfunction

  assign w_startIdx  = lowestIdx(i_mask);
  assign w_nextIdx   = lowestIdx(r_mask);
  assign w_startWord = i_q_flat[w_startIdx*WIDTH +: WIDTH];
  assign w_nextWord  = i_q_flat[w_nextIdx*WIDTH +: WIDTH];
  // m & (m-1) drops exactly the lowest set bit, matching the encoder's pick
  assign w_startRest = i_mask & (i_mask - NREG'(1));
  assign w_nextRest  = r_mask & (r_mask - NREG'(1));

`ifdef REG_DUMP_CHECKSUM_EN
  assign w_startLast = 1'b0;
  assign w_nextLast  = 1'b0;
`else
  assign w_startLast = (w_startRest == '0);
  assign w_nextLast  = (w_nextRest == '0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= S_IDLE;
      r_mask   <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_isCsum <= 1'b0;
      r_xor    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_mask != '0) begin
              r_state <= S_SEND;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_data  <= w_startWord;
              r_idx   <= w_startIdx;
              r_mask  <= w_startRest;
              r_last  <= w_startLast;
`ifdef REG_DUMP_CHECKSUM_EN
              r_isCsum <= 1'b0;
              r_xor    <= w_startWord;
`endif
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (i_ready) begin
            if (r_mask != '0) begin
              r_data <= w_nextWord;
              r_idx  <= w_nextIdx;
              r_mask <= w_nextRest;
              r_last <= w_nextLast;
`ifdef REG_DUMP_CHECKSUM_EN
              r_xor  <= r_xor ^ w_nextWord;
`endif
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              r_state  <= S_CSUM;
              r_data   <= r_xor;
              r_idx    <= '0;
              r_isCsum <= 1'b1;
              r_last   <= 1'b1;
`else
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (i_ready) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_last   <= 1'b0;
            r_isCsum <= 1'b0;
            r_done   <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_data_out = r_data;
  assign o_reg_idx  = r_idx;
  assign o_last     = r_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
`ifdef REG_DUMP_CHECKSUM_EN
  assign o_is_csum  = r_isCsum;
`else
  assign o_is_csum  = 1'b0;
`endif

endmodule
